// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width able to hold 0..width.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit combinational full adder used as the serial adder datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per cycle; done pulses WIDTH cycles after start.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = cnt_w(WIDTH);

  if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
    $error("serial_adder: WIDTH must be in 1..64");
  end

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic             w_load;
  logic [WIDTH-1:0] w_res_nxt;

  full_adder_cell u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_c),
    .sum  (w_s),
    .cout (w_co)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_load = start && (r_state != RUN);
  // New bit enters at the MSB; written as shift/OR so WIDTH=1 needs no empty slice.
  assign w_res_nxt = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (w_load) begin
      r_a   <= a;
      r_b   <= b;
      r_c   <= cin;
      r_res <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_co;
      r_res <= w_res_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        sum  <= w_res_nxt;
        cout <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
        // r_c is the carry into the MSB while the MSB is being processed.
        ovf  <= r_c ^ w_co;
`endif
      end
    end
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and sum width in bits; legal range 1..64.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: request to begin one addition.
REQ-005 SHALL have port a, input, WIDTH: operand A, sampled when start is accepted.
REQ-006 SHALL have port b, input, WIDTH: operand B, sampled when start is accepted.
REQ-007 SHALL have port cin, input, 1: carry-in, sampled when start is accepted.
REQ-008 SHALL have port busy, output, 1: addition in progress.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port sum, output, WIDTH: result of the last completed addition.
REQ-011 SHALL have port cout, output, 1: carry-out of the last completed addition.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE; busy = (state==RUN); done = (state==DONE).
REQ-013 SHALL accept start in IDLE or DONE: on that edge, load a, b and cin into internal shift/carry registers, clear the bit counter and enter RUN.
REQ-014 SHALL ignore start while in RUN, leaving the operation in flight unaffected.
REQ-015 SHALL, in RUN, process one bit per cycle, LSB first: sum bit = a_i^b_i^c and next c = majority(a_i,b_i,c); operands shift right and the result shifts in from the MSB.
REQ-016 SHALL enter DONE on the edge that processes bit WIDTH-1. With start accepted at edge t0, done is high exactly between edges t0+WIDTH and t0+WIDTH+1.
REQ-017 SHALL update sum and cout only on the edge entering DONE; both hold their previous values during RUN and hold indefinitely afterwards.
REQ-018 SHALL return from DONE to IDLE after one cycle unless start is high, in which case REQ-013 applies (back-to-back, no idle gap).
REQ-019 SHALL produce results modulo 2^WIDTH in sum, with the carry out of bit WIDTH-1 in cout.
REQ-020 SHALL work for WIDTH=1: done is high one cycle after the start edge.

Reset
REQ-021 SHALL, while rst is high, force state=IDLE, busy=0, done=0, sum=0, cout=0 and clear the counter, carry and shift registers, regardless of clk.
REQ-022 SHALL abort an operation in flight if rst is asserted mid-RUN: no done pulse, and sum/cout read 0.
REQ-023 SHALL, after rst is released, accept start at the first rising edge.

Configuration
REQ-024 SHALL recognise the macro SERIAL_ADDER_OVF_EN.
- Defined: output port ovf, 1 bit, = carry into bit WIDTH-1 XOR cout. It is captured with sum, reset to 0, and flags two's-complement signed overflow.
- Undefined: the ovf port and its logic are absent, and all other behaviour is identical.

Structure
REQ-025 SHALL take the state enum type (IDLE/RUN/DONE) from the shared package serial_adder_pkg.
REQ-026 SHALL take from serial_adder_pkg the counter-width constant function cnt_w(WIDTH) = $clog2(WIDTH+1).
REQ-027 SHALL instantiate exactly one combinational sub-module full_adder_cell (a, b, cin -> sum, cout) for the per-bit arithmetic.
REQ-028 SHALL reject WIDTH<1 at elaboration.

Verification
REQ-029 SHALL cover, at WIDTH=8, a=0xFF, b=0x01, cin=0 -> done exactly 8 cycles after the start edge, sum=0x00, cout=1, ovf=0.
REQ-030 SHALL cover, at WIDTH=8, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-031 SHALL cover, at WIDTH=8, a=0x12, b=0x34, start re-pulsed with a=0xFF, b=0xFF at cycle 3 -> the second start is ignored, sum=0x46, cout=0, one done pulse only.
REQ-032 SHALL cover start held high continuously with operand pairs (0x0F,0x01) then (0xA5,0x5A, cin=1) -> done pulses 9 cycles apart, sums 0x10 then 0x00 with cout=1.
REQ-033 SHALL cover rst asserted asynchronously at cycle 4 of RUN -> busy and done drop immediately, sum=0, no done pulse, and the next start completes normally.
REQ-034 SHALL cover WIDTH=1 exhaustively over all 8 (a,b,cin) combinations -> sum and cout match the full-adder truth table, with done one cycle after each start.
